// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that grants one requester at a time a burst of up to
// G_MAX_BURST beats into a single FIFO write port, stalling while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int G_WIDTH     = 8,
  parameter int G_NUM_REQ   = 4,
  parameter int G_MAX_BURST = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [G_NUM_REQ-1:0]           i_req_valid,
  input  logic [G_NUM_REQ*G_WIDTH-1:0]   i_req_data,
  output logic [G_NUM_REQ-1:0]           o_req_ready,
  output logic [G_NUM_REQ-1:0]           o_grant,
  output logic                           o_busy,
  output logic                           o_fifo_wr,
  output logic [G_WIDTH-1:0]             o_fifo_data,
  input  logic                           i_fifo_full
);

  localparam int IDX_W = $clog2(G_NUM_REQ);
  localparam int CNT_W = $clog2(G_MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(G_MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(G_NUM_REQ - 1);
  localparam logic [G_NUM_REQ-1:0] ONE_HOT0 = G_NUM_REQ'(1);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [G_NUM_REQ-1:0]   grant_q;

  logic [IDX_W-1:0]       rr_ptr_d;
  logic [CNT_W-1:0]       beat_cnt_d;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_found;
  logic                   in_burst;
  logic                   xfer;
  logic                   burst_end;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  // The loop runs from the farthest offset down, so the nearest valid requester
  // after rr_ptr_q is the last (winning) assignment.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = G_NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[(int'(rr_ptr_q) + i) % G_NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(rr_ptr_q) + i) % G_NUM_REQ);
      end
    end
  end

  // Reset masks the strobes combinationally so a partial burst writes nothing
  // more even in the cycle the synchronous reset is being applied.
  assign in_burst  = (state_q == ST_BURST);
  assign xfer      = in_burst && i_req_valid[gidx_q] && !i_fifo_full && !i_rst;
  assign beat_cnt_d = beat_cnt_q + 1'b1;
  assign rr_ptr_d  = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
  assign burst_end = !i_req_valid[gidx_q] || (xfer && (beat_cnt_d == MAX_CNT));

  assign o_busy      = in_burst;
  assign o_grant     = grant_q;
  assign o_fifo_wr   = xfer;
  assign o_req_ready = xfer ? grant_q : '0;
  assign o_fifo_data = (in_burst && !i_rst) ? i_req_data[int'(gidx_q) * G_WIDTH +: G_WIDTH]
                                            : '0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found && !i_fifo_full) begin
            state_q    <= ST_BURST;
            gidx_q     <= sel_idx;
            grant_q    <= ONE_HOT0 << sel_idx;
            beat_cnt_q <= '0;
          end
        end
        ST_BURST: begin
          if (xfer) begin
            beat_cnt_q <= beat_cnt_d;
          end
          if (burst_end) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios push expected writes,
// per-instance monitors pop and compare on every FIFO write strobe.
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic           busy, fifo_wr, fifo_full;
  logic [W-1:0]   fifo_data;

  logic [N-1:0]   req_valid1, req_ready1, grant1;
  logic [N*W-1:0] req_data1;
  logic           busy1, fifo_wr1, fifo_full1;
  logic [W-1:0]   fifo_data1;

  beat_t sb0[$];
  beat_t sb1[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] base [N];
  int         taken[N];

  fifo_wr_arbiter #(.G_WIDTH(W), .G_NUM_REQ(N), .G_MAX_BURST(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_grant(grant), .o_busy(busy), .o_fifo_wr(fifo_wr),
    .o_fifo_data(fifo_data), .i_fifo_full(fifo_full)
  );

  fifo_wr_arbiter #(.G_WIDTH(W), .G_NUM_REQ(N), .G_MAX_BURST(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid1), .i_req_data(req_data1),
    .o_req_ready(req_ready1), .o_grant(grant1), .o_busy(busy1), .o_fifo_wr(fifo_wr1),
    .o_fifo_data(fifo_data1), .i_fifo_full(fifo_full1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [N-1:0] g);
    idx_of = '0;
    for (int k = 0; k < N; k++) if (g[k]) idx_of = 2'(k);
  endfunction

  task automatic push0(input logic [1:0] s, input logic [7:0] d);
    beat_t e;
    e.src = s; e.data = d;
    sb0.push_back(e);
  endtask

  task automatic push1(input logic [1:0] s, input logic [7:0] d);
    beat_t e;
    e.src = s; e.data = d;
    sb1.push_back(e);
  endtask

  task automatic drive_data();
    for (int k = 0; k < N; k++) req_data[k*W +: W] = base[k] + 8'(taken[k]);
  endtask

  // Each requester presents base+beats_accepted; a beat is consumed when
  // ready&valid is seen before the edge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) taken[k]++;
    drive_data();
  endtask

  task automatic expect_dut(input string tag, input logic b, input logic [N-1:0] g,
                            input logic w, input logic [N-1:0] r);
    #1;
    check({tag, "_busy"},  32'(busy),      32'(b));
    check({tag, "_grant"}, 32'(grant),     32'(g));
    check({tag, "_wr"},    32'(fifo_wr),   32'(w));
    check({tag, "_ready"}, 32'(req_ready), 32'(r));
  endtask

  task automatic expect_dut1(input string tag, input logic b, input logic [N-1:0] g,
                             input logic w);
    #1;
    check({tag, "_busy"},  32'(busy1),    32'(b));
    check({tag, "_grant"}, 32'(grant1),   32'(g));
    check({tag, "_wr"},    32'(fifo_wr1), 32'(w));
  endtask

  always @(negedge clk) begin
    beat_t e;
    check("inv0_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    check("inv0_wr_full", 32'(fifo_wr & fifo_full), 32'd0);
    if (fifo_wr) begin
      if (sb0.size() == 0) begin
        check("sb0_unexpected_write", 32'(fifo_data), 32'hFFFF_FFFF);
      end else begin
        e = sb0.pop_front();
        check("sb0_src",  32'(idx_of(grant)), 32'(e.src));
        check("sb0_data", 32'(fifo_data),     32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    check("inv1_ready_onehot", 32'($countones(req_ready1) <= 1), 32'd1);
    if (fifo_wr1) begin
      if (sb1.size() == 0) begin
        check("sb1_unexpected_write", 32'(fifo_data1), 32'hFFFF_FFFF);
      end else begin
        e = sb1.pop_front();
        check("sb1_src",  32'(idx_of(grant1)), 32'(e.src));
        check("sb1_data", 32'(fifo_data1),     32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    fifo_full  = 1'b0;
    req_valid1 = '0;
    fifo_full1 = 1'b0;
    base[0] = 8'h40; base[1] = 8'h50; base[2] = 8'h10; base[3] = 8'h30;
    for (int k = 0; k < N; k++) taken[k] = 0;
    drive_data();
    for (int k = 0; k < N; k++) req_data1[k*W +: W] = 8'hA0 + 8'(k);

    // Reset: outputs quiet even with every requester valid
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    check("rst_data", 32'(fifo_data), 32'd0);
    expect_dut("rst", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    rst = 1'b0;
    req_valid = '0;
    expect_dut("post_rst", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();

    // Single requester, bursts of 4 with one idle gap, then regrant
    for (int i = 0; i < 6; i++) push0(2'd2, 8'h10 + 8'(i));
    req_valid = 4'b0100;
    expect_dut("a_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_dut("a_beat", 1'b1, 4'b0100, 1'b1, 4'b0100);
      tick();
    end
    expect_dut("a_gap", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      expect_dut("a_regrant", 1'b1, 4'b0100, 1'b1, 4'b0100);
      tick();
    end
    req_valid = '0;
    expect_dut("a_forfeit", 1'b1, 4'b0100, 1'b0, 4'b0000);
    tick();
    expect_dut("a_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();

    // Full stall mid-burst on requester 3
    for (int i = 0; i < 4; i++) push0(2'd3, 8'h30 + 8'(i));
    req_valid = 4'b1000;
    expect_dut("c_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      expect_dut("c_beat", 1'b1, 4'b1000, 1'b1, 4'b1000);
      tick();
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_dut("c_stall", 1'b1, 4'b1000, 1'b0, 4'b0000);
      tick();
    end
    fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_dut("c_resume", 1'b1, 4'b1000, 1'b1, 4'b1000);
      tick();
    end
    req_valid = '0;
    expect_dut("c_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();

    // Early release by requester 1; rr_ptr moves to 2
    push0(2'd1, 8'h50);
    push0(2'd1, 8'h51);
    req_valid = 4'b0010;
    expect_dut("d_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      expect_dut("d_beat", 1'b1, 4'b0010, 1'b1, 4'b0010);
      tick();
    end
    req_valid = 4'b0100;
    expect_dut("d_release", 1'b1, 4'b0010, 1'b0, 4'b0000);
    tick();
    push0(2'd2, 8'h16);
    req_valid = 4'b0110;
    expect_dut("d_gap", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    expect_dut("d_grant2", 1'b1, 4'b0100, 1'b1, 4'b0100);
    tick();
    req_valid = '0;
    expect_dut("d_drop", 1'b1, 4'b0100, 1'b0, 4'b0000);
    tick();
    expect_dut("d_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();

    // Reset during beat 3 of requester 3
    push0(2'd3, 8'h34);
    push0(2'd3, 8'h35);
    req_valid = 4'b1000;
    expect_dut("e_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      expect_dut("e_beat", 1'b1, 4'b1000, 1'b1, 4'b1000);
      tick();
    end
    rst = 1'b1;
    #1;
    check("e_rst_wr",    32'(fifo_wr),   32'd0);
    check("e_rst_ready", 32'(req_ready), 32'd0);
    check("e_rst_data",  32'(fifo_data), 32'd0);
    tick();
    rst = 1'b0;
    push0(2'd0, 8'h40);
    req_valid = 4'b1111;
    expect_dut("e_after_rst", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    expect_dut("e_grant0", 1'b1, 4'b0001, 1'b1, 4'b0001);
    tick();
    req_valid = '0;
    expect_dut("e_drop", 1'b1, 4'b0001, 1'b0, 4'b0000);
    tick();
    expect_dut("e_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();

    // Full while idle blocks granting; grant the cycle after full drops
    push0(2'd1, 8'h52);
    req_valid = 4'b1111;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_dut("f_full_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);
      tick();
    end
    fifo_full = 1'b0;
    expect_dut("f_release", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();
    expect_dut("f_grant1", 1'b1, 4'b0010, 1'b1, 4'b0010);
    tick();
    req_valid = '0;
    expect_dut("f_drop", 1'b1, 4'b0010, 1'b0, 4'b0000);
    tick();
    expect_dut("f_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    tick();

    // Round robin with single-beat bursts on the second instance
    for (int i = 0; i < 5; i++) push1(2'(i % 4), 8'hA0 + 8'(i % 4));
    req_valid1 = 4'b1111;
    expect_dut1("rr_idle", 1'b0, 4'b0000, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        expect_dut1("rr_grant", 1'b1, 4'b0001, 1'b1);
        tick();
      end else begin
        expect_dut1("rr_grant", 1'b1, 4'(1 << i), 1'b1);
        tick();
        expect_dut1("rr_gap", 1'b0, 4'b0000, 1'b0);
        tick();
      end
    end
    req_valid1 = '0;
    expect_dut1("rr_end", 1'b0, 4'b0000, 1'b0);
    tick();

    repeat (3) tick();
    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
